// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to the tx and rx FSMs)
// and the idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Clocks-per-bit counter: wraps 0..CLKS_PER_BIT-1 while enabled and flags
// the last cycle of each bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// one stop bit. All outputs registered from the next-state decode.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_t          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_tick;
  logic                 w_clear;
  logic                 w_en;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  assign w_clear = (r_state == IDLE);
  assign w_en    = (r_state != IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .en      (w_en),
    .bit_tick(w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_par_nxt   = r_par;
    w_done_nxt  = 1'b0;
    w_tx_nxt    = LINE_IDLE;
    w_busy_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_state_nxt = START;
          w_shift_nxt = tx_data;
          w_par_nxt   = parity_bit(tx_data);
          w_bit_nxt   = '0;
        end
      end
      START: begin
        if (w_tick) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == LAST_BIT) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level is decoded from the state being entered so tx comes straight off a flop.
    case (w_state_nxt)
      START:  begin w_tx_nxt = 1'b0;           w_busy_nxt = 1'b1; end
      DATA:   begin w_tx_nxt = w_shift_nxt[0]; w_busy_nxt = 1'b1; end
      PARITY: begin w_tx_nxt = w_par_nxt;      w_busy_nxt = 1'b1; end
      STOP:   begin w_tx_nxt = 1'b1;           w_busy_nxt = 1'b1; end
      default: begin w_tx_nxt = LINE_IDLE;     w_busy_nxt = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tx    <= LINE_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (even parity, odd parity, no
// parity) at 4 clocks per bit, with a mid-bit sampling receiver model.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic [2:0] start_r;
  logic [7:0] data_r [3];
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;

  int checks   = 0;
  int failures = 0;

  logic tr [256];
  int   n_busy, n_done, done_at;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset(reset), .tx_start(start_r[0]), .tx_data(data_r[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .tx_start(start_r[1]), .tx_data(data_r[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .reset(reset), .tx_start(start_r[2]), .tx_data(data_r[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse tx_start on instance sel and record tx per cycle (tr[c], c=1 is the
  // first cycle after acceptance). Optional mid-frame start injection and a
  // back-to-back start issued in the first done cycle.
  task automatic run(input int sel, input logic [7:0] d, input int inj_c,
                     input logic [7:0] inj_d, input bit b2b, input logic [7:0] d2,
                     input int ncyc);
    for (int i = 0; i < 256; i++) tr[i] = 1'b1;
    n_busy = 0; n_done = 0; done_at = 0;
    @(negedge clk);
    tr[0] = tx_w[sel];
    start_r[sel] = 1'b1;
    data_r[sel]  = d;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start_r[sel] = 1'b0;
      tr[c] = tx_w[sel];
      if (busy_w[sel]) n_busy++;
      if (done_w[sel]) begin
        n_done++;
        if (done_at == 0) done_at = c;
        if (b2b && n_done == 1) begin
          start_r[sel] = 1'b1;
          data_r[sel]  = d2;
        end
      end
      if (c == inj_c) begin
        start_r[sel] = 1'b1;
        data_r[sel]  = inj_d;
      end
    end
  endtask

  // Receiver model: find the start bit, sample each 4-cycle slot and count
  // any cycle whose level differs from its slot's sample.
  task automatic rx(input int from, input int pe, output int sp, output logic [7:0] d,
                    output logic p, output logic s, output int unstable);
    logic v;
    int   last;
    sp = -1; d = '0; p = 1'b0; s = 1'b0; unstable = 0;
    for (int c = from; c < 128; c++) if (sp < 0 && tr[c] === 1'b0) sp = c;
    if (sp >= 0) begin
      last = 9 + pe;
      for (int k = 0; k <= last; k++) begin
        v = tr[sp + 4*k + 1];
        for (int j = 0; j < 4; j++) if (tr[sp + 4*k + j] !== v) unstable++;
        if (k >= 1 && k <= 8) d[k-1] = v;
        if (pe != 0 && k == 9) p = v;
        if (k == last) s = v;
      end
    end
  endtask

  initial begin
    int         sp, unst, bad;
    logic [7:0] d;
    logic       p, s;

    reset = 1'b1;
    start_r = '0;
    for (int i = 0; i < 3; i++) data_r[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx",   {29'd0, tx_w},   32'h7);
    chk("reset_busy", {29'd0, busy_w}, 32'h0);
    chk("reset_done", {29'd0, done_w}, 32'h0);
    reset = 1'b0;

    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_w !== 3'b111 || busy_w !== 3'b000 || done_w !== 3'b000) bad++;
    end
    chk("idle_100", bad, 0);

    // 0xA5, even parity
    run(0, 8'hA5, 0, 8'h00, 1'b0, 8'h00, 60);
    rx(1, 1, sp, d, p, s, unst);
    chk("a5_start_pos", sp, 1);
    chk("a5_data", {24'd0, d}, 32'hA5);
    chk("a5_parity", {31'd0, p}, 0);
    chk("a5_stop", {31'd0, s}, 1);
    chk("a5_stable", unst, 0);
    chk("a5_busy_cycles", n_busy, 44);
    chk("a5_done_count", n_done, 1);
    chk("a5_done_at", done_at, 45);
    chk("a5_done_cycle_tx", {31'd0, tr[45]}, 1);

    // odd parity on all-zero data
    run(1, 8'h00, 0, 8'h00, 1'b0, 8'h00, 60);
    rx(1, 1, sp, d, p, s, unst);
    chk("odd_data", {24'd0, d}, 0);
    chk("odd_parity", {31'd0, p}, 1);
    chk("odd_stop", {31'd0, s}, 1);
    chk("odd_busy_cycles", n_busy, 44);

    // no parity, 0xFF: 10 slots
    run(2, 8'hFF, 0, 8'h00, 1'b0, 8'h00, 60);
    rx(1, 0, sp, d, p, s, unst);
    chk("nopar_data", {24'd0, d}, 32'hFF);
    chk("nopar_stop", {31'd0, s}, 1);
    chk("nopar_stable", unst, 0);
    chk("nopar_busy_cycles", n_busy, 40);
    chk("nopar_done_at", done_at, 41);

    // start request during slot 3 is ignored
    run(0, 8'h3C, 13, 8'h12, 1'b0, 8'h00, 80);
    rx(1, 1, sp, d, p, s, unst);
    chk("ign_data", {24'd0, d}, 32'h3C);
    chk("ign_parity", {31'd0, p}, 0);
    chk("ign_busy_cycles", n_busy, 44);
    chk("ign_done_count", n_done, 1);
    rx(46, 1, sp, d, p, s, unst);
    chk("ign_no_second_frame", sp, -1);

    // back-to-back, second start issued in the done cycle
    run(0, 8'h3C, 0, 8'h00, 1'b1, 8'hC3, 100);
    rx(1, 1, sp, d, p, s, unst);
    chk("b2b_first_data", {24'd0, d}, 32'h3C);
    chk("b2b_gap_tx", {31'd0, tr[45]}, 1);
    rx(45, 1, sp, d, p, s, unst);
    chk("b2b_second_start", sp, 46);
    chk("b2b_second_data", {24'd0, d}, 32'hC3);
    chk("b2b_second_parity", {31'd0, p}, 0);
    chk("b2b_second_stop", {31'd0, s}, 1);
    chk("b2b_stable", unst, 0);
    chk("b2b_done_count", n_done, 2);
    chk("b2b_busy_cycles", n_busy, 88);

    // asynchronous reset in the middle of a 0x55 frame
    @(negedge clk);
    start_r[0] = 1'b1;
    data_r[0]  = 8'h55;
    repeat (12) begin
      @(negedge clk);
      start_r[0] = 1'b0;
    end
    chk("mid_pre_tx", {31'd0, tx_w[0]}, 0);
    chk("mid_pre_busy", {31'd0, busy_w[0]}, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_async_tx", {31'd0, tx_w[0]}, 1);
    chk("mid_async_busy", {31'd0, busy_w[0]}, 0);
    chk("mid_async_done", {31'd0, done_w[0]}, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    run(0, 8'h0F, 0, 8'h00, 1'b0, 8'h00, 60);
    rx(1, 1, sp, d, p, s, unst);
    chk("post_start_pos", sp, 1);
    chk("post_data", {24'd0, d}, 32'h0F);
    chk("post_parity", {31'd0, p}, 0);
    chk("post_stable", unst, 0);
    chk("post_done_at", done_at, 45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
